// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the 1RW SRAM initiator: controller states and the default trim code.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        INIT     = 2'd1,
        RUN      = 2'd2
    } ctrl_state_e;

    localparam logic [2:0] TRIM_DEFAULT = 3'b000;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO: circular buffer with an occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sram_rsp_fifo #(
    parameter int DataWidth = 32,
    parameter int Depth     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DataWidth-1:0]       wdata,
    input  logic                       pop,
    output logic [DataWidth-1:0]       rdata,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CountWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FullCount);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sram_1rw_initiator.sv
// Single-port 1RW SRAM initiator: turns a read/masked-write request stream into macro pin
// activity and returns read data, in order, through a small response FIFO.
module sram_1rw_initiator
    import sram_ctrl_pkg::*;
#(
    parameter int         AddressWidth = 9,
    parameter int         DataWidth    = 32,
    parameter int         wrMaskWidth  = 4,
    parameter int         RspDepth     = 2,
    parameter bit         InitOnReset  = 1'b1,
    parameter logic [2:0] TrimValue    = TRIM_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [DataWidth-1:0]    req_wdata,
    input  logic [wrMaskWidth-1:0]  req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    init_done,
    output logic [AddressWidth-1:0] sram_addr,
    output logic [DataWidth-1:0]    sram_d,
    input  logic [DataWidth-1:0]    sram_q,
    output logic                    sram_ce_n,
    output logic                    sram_wr_n,
    output logic [wrMaskWidth-1:0]  sram_wr_mask_n,
    output logic                    sram_cmbist,
    output logic                    sram_cmatpg,
    output logic [2:0]              sram_sramtrm
);

    localparam int CountWidth = $clog2(RspDepth + 1);
    localparam logic [CountWidth:0] RspLimit = (CountWidth + 1)'(RspDepth);

    ctrl_state_e             state_q;
    ctrl_state_e             state_d;
    logic [AddressWidth:0]   init_cnt_q;
    logic [AddressWidth:0]   init_cnt_d;
    logic                    inflight_q;
    logic [AddressWidth-1:0] addr_q;
    logic [DataWidth-1:0]    d_q;
    logic [CountWidth-1:0]   fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CountWidth:0]     occupancy;
    logic                    accept;
    logic                    rsp_pop;

    // Next state; the extra counter bit flags the write to the last address.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            RST_WAIT: state_d = InitOnReset ? INIT : RUN;
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_d[AddressWidth]) state_d = RUN;
            end
            RUN:      state_d = RUN;
            default:  state_d = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RST_WAIT;
            init_cnt_q <= '0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
            d_q        <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            inflight_q <= accept && !req_we;
            addr_q     <= sram_addr;
            d_q        <= sram_d;
        end
    end

    // Reserve a FIFO slot for every read still in the macro pipeline.
    assign occupancy = {1'b0, fifo_count} + {{CountWidth{1'b0}}, inflight_q};
    assign req_ready = (state_q == RUN) && !fifo_full && (occupancy < RspLimit);
    assign accept    = req_valid && req_ready;
    assign init_done = (state_q == RUN);

    // Address and data buses park on their last value when the macro is idle.
    always_comb begin
        sram_ce_n      = 1'b1;
        sram_wr_n      = 1'b1;
        sram_wr_mask_n = '1;
        sram_addr      = addr_q;
        sram_d         = d_q;
        if (state_q == INIT) begin
            sram_ce_n      = 1'b0;
            sram_wr_n      = 1'b0;
            sram_wr_mask_n = '0;
            sram_addr      = init_cnt_q[AddressWidth-1:0];
            sram_d         = '0;
        end else if (accept) begin
            sram_ce_n      = 1'b0;
            sram_wr_n      = ~req_we;
            sram_wr_mask_n = req_we ? ~req_wmask : '1;
            sram_addr      = req_addr;
            sram_d         = req_wdata;
        end
    end

    assign sram_cmbist  = 1'b0;
    assign sram_cmatpg  = 1'b0;
    assign sram_sramtrm = TrimValue;

    assign rsp_valid = !fifo_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    sram_rsp_fifo #(
        .DataWidth (DataWidth),
        .Depth     (RspDepth)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight_q),
        .wdata   (sram_q),
        .pop     (rsp_pop),
        .rdata   (rsp_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_sram_1rw_initiator.sv
// Bench for sram_1rw_initiator: macro model with garbage power-up contents, reference memory
// plus expected-response queue, and a monitor that scores every response handshake.
module tb_sram_1rw_initiator;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int LW    = DW / MW;
    localparam int DEPTH = 2;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_wmask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;
    logic          sram_ce_n;
    logic          sram_wr_n;
    logic [MW-1:0] sram_wr_mask_n;
    logic          sram_cmbist;
    logic          sram_cmatpg;
    logic [2:0]    sram_sramtrm;

    sram_1rw_initiator #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .wrMaskWidth  (MW),
        .RspDepth     (DEPTH),
        .InitOnReset  (1'b1),
        .TrimValue    (3'b000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_addr      (sram_addr),
        .sram_d         (sram_d),
        .sram_q         (sram_q),
        .sram_ce_n      (sram_ce_n),
        .sram_wr_n      (sram_wr_n),
        .sram_wr_mask_n (sram_wr_mask_n),
        .sram_cmbist    (sram_cmbist),
        .sram_cmatpg    (sram_cmatpg),
        .sram_sramtrm   (sram_sramtrm)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic          rand_ready = 1'b0;
    logic [DW-1:0] ref_mem   [WORDS];
    logic [DW-1:0] macro_mem [WORDS];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_d = '0;
    logic [MW-1:0] seen_mask = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Macro model: 1-cycle read, active-low byte-lane write mask, random power-up contents.
    initial for (int i = 0; i < WORDS; i++) macro_mem[i] = $urandom;
    always @(posedge clk) begin
        if (!sram_ce_n) begin
            if (!sram_wr_n) begin
                for (int l = 0; l < MW; l++)
                    if (!sram_wr_mask_n[l]) macro_mem[sram_addr][l*LW +: LW] = sram_d[l*LW +: LW];
            end else begin
                sram_q <= macro_mem[sram_addr];
            end
        end
    end

    // Response monitor: scores each handshake and checks data holds while stalled.
    logic          held = 1'b0;
    logic [DW-1:0] held_data = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                check("rsp_hold_data", 64'(rsp_rdata), 64'(held_data));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=%0h expected=none t=%0t", rsp_rdata, $time);
                end else begin
                    check("rsp_data", 64'(rsp_rdata), 64'(exp_q.pop_front()));
                end
                held = 1'b0;
            end else if (rsp_valid) begin
                held = 1'b1;
                held_data = rsp_rdata;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Issue one request; returns 1 time unit after the accepting edge with req_valid still high.
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [MW-1:0] mask);
        int waited = 0;
        logic [MW-1:0] exp_mask;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL req_timeout actual=no_accept expected=accept addr=%0h", addr);
                req_valid = 1'b0;
                return;
            end
            next_cycle();
        end
        exp_mask = we ? ~mask : {MW{1'b1}};
        seen_mask = sram_wr_mask_n;
        check("acc_ce_n", 64'(sram_ce_n), 64'd0);
        check("acc_wr_n", 64'(sram_wr_n), 64'(!we));
        check("acc_mask_n", 64'(sram_wr_mask_n), 64'(exp_mask));
        check("acc_addr", 64'(sram_addr), 64'(addr));
        check("acc_d", 64'(sram_d), 64'(wdata));
        if (we) begin
            for (int l = 0; l < MW; l++)
                if (mask[l]) ref_mem[addr][l*LW +: LW] = wdata[l*LW +: LW];
        end else begin
            exp_q.push_back(ref_mem[addr]);
        end
        exp_addr = addr;
        exp_d    = wdata;
        next_cycle();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_ce_n", 64'(sram_ce_n), 64'd1);
            check("idle_addr", 64'(sram_addr), 64'(exp_addr));
            check("idle_d", 64'(sram_d), 64'(exp_d));
            next_cycle();
        end
    endtask

    // Called 1 time unit after reset_n rises; counts edges until init_done.
    task automatic wait_init();
        int n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                check("init_ce_n", 64'(sram_ce_n), 64'd0);
                check("init_wr_n", 64'(sram_wr_n), 64'd0);
                check("init_mask_n", 64'(sram_wr_mask_n), 64'd0);
                check("init_addr0", 64'(sram_addr), 64'd0);
                check("init_d", 64'(sram_d), 64'd0);
                check("init_req_ready", 64'(req_ready), 64'd0);
                check("init_rsp_valid", 64'(rsp_valid), 64'd0);
            end
            if (n == 2) check("init_addr1", 64'(sram_addr), 64'd1);
            if (init_done || n > 1000) break;
        end
        check("init_latency", 64'(n), 64'd513);
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        exp_addr = AW'(WORDS - 1);
        exp_d    = '0;
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_ce_n", 64'(sram_ce_n), 64'd1);
        check("rst_wr_n", 64'(sram_wr_n), 64'd1);
        check("rst_mask_n", 64'(sram_wr_mask_n), 64'hF);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_d", 64'(sram_d), 64'd0);
        check("tie_cmbist", 64'(sram_cmbist), 64'd0);
        check("tie_cmatpg", 64'(sram_cmatpg), 64'd0);
        check("tie_trim", 64'(sram_sramtrm), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_init();

        // Top address reads back zero after the fill.
        do_req(1'b0, 9'h1FF, '0, '0);
        idle(3);

        // Full write, then read latency of two cycles.
        do_req(1'b1, 9'h010, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 9'h010, '0, '0);
        req_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", 64'(rsp_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check("lat_cycle2", 64'(rsp_valid), 64'd1);
        next_cycle();
        idle(2);

        // Single-lane write, then a zero-mask write that must leave the word alone.
        do_req(1'b1, 9'h010, 32'h0000AB00, 4'b0010);
        check("lane_mask_n", 64'(seen_mask), 64'(4'b1101));
        do_req(1'b1, 9'h010, 32'hFFFFFFFF, 4'b0000);
        do_req(1'b0, 9'h010, '0, '0);
        idle(3);

        // Backpressure: only RspDepth reads accepted while the consumer stalls.
        for (int i = 0; i < 4; i++) do_req(1'b1, AW'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        idle(2);
        rsp_ready = 1'b0;
        do_req(1'b0, 9'h000, '0, '0);
        do_req(1'b0, 9'h001, '0, '0);
        req_we   = 1'b0;
        req_addr = 9'h002;
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        do_req(1'b0, 9'h002, '0, '0);
        do_req(1'b0, 9'h003, '0, '0);
        idle(4);

        // Back-to-back write/read of the same word, idle bus parks on that address.
        do_req(1'b1, 9'h020, 32'h12345678, 4'hF);
        do_req(1'b0, 9'h020, '0, '0);
        idle(3);

        // Random mix with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                   MW'($urandom_range(0, 15)));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        rand_ready = 1'b0;
        rsp_ready  = 1'b1;
        idle(2);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        // Mid-operation reset with two reads outstanding.
        rsp_ready = 1'b0;
        do_req(1'b0, 9'h005, '0, '0);
        do_req(1'b0, 9'h006, '0, '0);
        req_valid = 1'b0;
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_ce_n", 64'(sram_ce_n), 64'd1);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_init_done", 64'(init_done), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        wait_init();
        do_req(1'b0, 9'h005, '0, '0);
        idle(4);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
